// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute controller and accumulator for the 8-bit accumulator CPU.
// Latency: ALU op 4 cycles, LDA/STA 3, JMP/JZ/HLT 2 (zero-wait); request raised one cycle after reset release.
// Backpressure: FETCH/OPREAD/STORE stall until mem_ready with all request outputs held stable.
module acc_cpu_ctrl #(
    parameter int                 ADDR_W   = 5,
    parameter int                 DATA_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              zero,
    output logic              halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_OPREAD = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_LDA = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    logic [2:0]        state, nxt_state;
    logic [ADDR_W-1:0] pc, nxt_pc;
    logic [DATA_W-1:0] ir, nxt_ir;
    logic [DATA_W-1:0] acc, nxt_acc;
    logic [DATA_W-1:0] operand, nxt_operand;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              fire;

    assign opcode    = ir[DATA_W-1 -: 3];
    assign ir_addr   = ir[ADDR_W-1:0];
    // mem_req is low in the first FETCH cycle after reset, so a stray mem_ready there is ignored
    assign fire      = mem_req & mem_ready;

    assign mem_wdata = acc;
    assign alu_a     = acc;
    assign alu_b     = operand;
    assign acc_out   = acc;
    assign pc_out    = pc;
    assign zero      = (acc == '0);

    always_comb begin
        alu_op = 2'b00;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND)
            alu_op = ir[DATA_W-2 -: 2];
    end

    always_comb begin
        nxt_state   = state;
        nxt_pc      = pc;
        nxt_ir      = ir;
        nxt_acc     = acc;
        nxt_operand = operand;
        case (state)
            S_FETCH: begin
                if (fire) begin
                    nxt_ir    = mem_rdata;
                    nxt_pc    = pc + ADDR_W'(1);
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_LDA: nxt_state = S_OPREAD;
                    OP_STA:  nxt_state = S_STORE;
                    OP_JMP: begin
                        nxt_pc    = ir_addr;
                        nxt_state = S_FETCH;
                    end
                    OP_JZ: begin
                        if (zero) nxt_pc = ir_addr;
                        nxt_state = S_FETCH;
                    end
                    OP_HLT:  nxt_state = S_HALT;
                    default: nxt_state = S_FETCH;
                endcase
            end
            S_OPREAD: begin
                if (fire) begin
                    if (opcode == OP_LDA) begin
                        nxt_acc   = mem_rdata;
                        nxt_state = S_FETCH;
                    end else begin
                        nxt_operand = mem_rdata;
                        nxt_state   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                nxt_acc   = alu_result;
                nxt_state = S_FETCH;
            end
            S_STORE: begin
                if (fire) nxt_state = S_FETCH;
            end
            S_HALT:  nxt_state = S_HALT;
            default: nxt_state = S_FETCH;
        endcase
    end

    // Request outputs are flops loaded from the next-state view, keeping mem_ready off any output path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            acc      <= '0;
            operand  <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= RESET_PC;
            halted   <= 1'b0;
        end else begin
            state    <= nxt_state;
            pc       <= nxt_pc;
            ir       <= nxt_ir;
            acc      <= nxt_acc;
            operand  <= nxt_operand;
            mem_req  <= (nxt_state == S_FETCH) || (nxt_state == S_OPREAD) || (nxt_state == S_STORE);
            mem_we   <= (nxt_state == S_STORE);
            mem_addr <= (nxt_state == S_FETCH) ? nxt_pc : nxt_ir[ADDR_W-1:0];
            halted   <= (nxt_state == S_HALT);
        end
    end

endmodule

// File: doc/acc_cpu_ctrl.md
Name: acc_cpu_ctrl

Overview:
- Fetch/decode/execute controller and accumulator for the 8-bit accumulator CPU.
- Sits directly upstream of the ALU: drives its a, b and op inputs, and captures its result into the ACC.
- Talks to a single-port 32x8 unified instruction/data memory through a req/ready handshake.
- Instruction format: opcode[7:5], address[4:0].

Parameters:
- ADDR_W, 5, memory address / PC width. Instruction address field is ir[ADDR_W-1:0].
- DATA_W, 8, data, ACC and instruction width. Must equal 3+ADDR_W.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory access request
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  ADDR_W  access address; valid while mem_req=1
- mem_wdata  out  DATA_W  store data (=ACC); valid while mem_we=1
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  access complete; sampled only while mem_req=1
- alu_a  out  DATA_W  ALU operand a, always equals ACC
- alu_b  out  DATA_W  ALU operand b, equals operand register
- alu_op  out  2  00 ADD, 01 SUB, 10 AND; equals ir[6:5] for ALU opcodes, else 00
- alu_result  in  DATA_W  combinational ALU result
- acc_out  out  DATA_W  ACC value
- pc_out  out  ADDR_W  PC value
- zero  out  1  combinational, (ACC==0)
- halted  out  1  1 while in HALT

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, acc=0, ir=0, operand=0, state=FETCH.
  - mem_req=0, mem_we=0, halted=0.
  - Reset mid-access aborts the access immediately; mem_req drops asynchronously.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND
  - 011 LDA (acc<=M[a])
  - 100 STA (M[a]<=acc)
  - 101 JMP (pc<=a)
  - 110 JZ (pc<=a if zero)
  - 111 HLT
- Registered FSM outputs: mem_req, mem_we, mem_addr and halted are driven from state and registers only. No combinational path from mem_ready to any request output.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: ir<=mem_rdata; pc<=pc+1 modulo 2^ADDR_W (31 wraps to 0); go to DECODE.
- DECODE: one cycle, mem_req=0.
  - ALU opcodes and LDA: go to OPREAD.
  - STA: go to STORE.
  - JMP: pc<=ir[4:0], go to FETCH.
  - JZ: if zero, pc<=ir[4:0]; otherwise pc unchanged; go to FETCH. zero is evaluated on the current ACC.
  - HLT: go to HALT.
- OPREAD:
  - mem_req=1, mem_we=0, mem_addr=ir[4:0].
  - On mem_ready, LDA: acc<=mem_rdata, go to FETCH.
  - On mem_ready, ALU opcode: operand<=mem_rdata, go to EXEC.
- EXEC: one cycle. acc<=alu_result, go to FETCH. ALU wrap-around is inherent: modulo 256, no carry or overflow flag.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=ir[4:0], mem_wdata=acc.
  - On mem_ready: go to FETCH.
- HALT: mem_req=0, halted=1. State is held indefinitely; only rst_n exits.
- Handshake rules:
  - Once asserted, mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ready=1 is sampled.
  - Zero-wait memory is legal: mem_ready may be high in the first req cycle.
  - mem_ready while mem_req=0 is ignored.
  - Arbitrary wait states are tolerated with no timeout.
- Instruction latency with zero-wait memory:
  - ALU op: 4 cycles (FETCH, DECODE, OPREAD, EXEC).
  - LDA and STA: 3 cycles.
  - JMP, JZ and HLT: 2 cycles.
- Self-modifying code: STA into the next instruction's address takes effect. The fetch always reads memory afresh.

Test Plan:
- Reset: assert rst_n=0 mid-OPREAD with mem_req=1 -> mem_req=0 immediately; after release acc=0, pc=0, FETCH with mem_addr=0.
- Program LDA 10; ADD 11; SUB 12; AND 13; STA 14; HLT with M[10]=0x05, M[11]=0xFC, M[12]=0x02, M[13]=0x0F and zero-wait memory:
  - ADD gives acc=0x01, SUB gives acc=0xFF, AND gives acc=0x0F.
  - STA writes M[14]=0x0F with mem_we=1 for one cycle.
  - halted=1 at the predicted cycle count (3+4+4+4+3+2).
- Branches:
  - JZ 5 with acc=0 -> next fetch address 5.
  - JZ 5 with acc=0x01 -> next fetch address pc+1.
  - JMP 31 followed by a non-branch at 31 -> pc wraps to 0.
- Wait states: mem_ready delayed 3 cycles on every access -> mem_req, mem_addr and mem_wdata stable throughout; final results identical to zero-wait; each instruction takes 3 extra cycles per access.
- Overflow: ADD 0xFF+0x01 gives acc=0x00 and zero=1; SUB 0x00-0x01 gives acc=0xFF.
- HALT: after HLT, toggle mem_ready randomly for 50 cycles -> no mem_req; acc, pc and halted=1 unchanged.
